// File: rtl/falafel_req_arbiter.sv
// Round-robin front end that shares one falafel allocator between NUM_REQ requesters.
// Only one alloc/free is in flight at a time. The winning request is latched and issued
// to falafel. The result is captured and handed back to the requester that owns it.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      per-requester request handshake (ready is one-hot or zero)
//   req_is_alloc_i, req_data_i     per-requester op type and size/address (DATA_W each)
//   rsp_valid_o / rsp_ready_i      per-requester result handshake (valid is one-hot or zero)
//   rsp_data_o, rsp_is_write_o     shared result payload
//   fal_req_*, fal_is_alloc_o,
//   fal_size_o, fal_addr_o         request interface towards falafel
//   fal_rsp_*                      result interface from falafel
//   owner_o                        current/last granted requester
//   busy_o                         high whenever an operation is in progress
module falafel_req_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ-1:0]          req_is_alloc_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    input  logic [NUM_REQ-1:0]          rsp_ready_i,
    output logic [DATA_W-1:0]           rsp_data_o,
    output logic                        rsp_is_write_o,
    output logic                        fal_req_valid_o,
    input  logic                        fal_req_ready_i,
    output logic                        fal_is_alloc_o,
    output logic [DATA_W-1:0]           fal_size_o,
    output logic [DATA_W-1:0]           fal_addr_o,
    input  logic                        fal_rsp_valid_i,
    output logic                        fal_rsp_ready_o,
    input  logic [DATA_W-1:0]           fal_rsp_data_i,
    input  logic                        fal_rsp_is_write_i,
    output logic [IDX_W-1:0]            owner_o,
    output logic                        busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRsp,
        StDeliver
    } state_e;

    localparam logic [NUM_REQ-1:0] OneHotLsb = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic                is_alloc_q, is_alloc_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_is_write_q, rsp_is_write_d;

    logic                grant_found;
    logic [IDX_W-1:0]    grant_idx;
    int unsigned         cand;

    // Search starts just after the last completed owner, so the requester served most
    // recently has the lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && req_valid_i[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        is_alloc_d     = is_alloc_q;
        data_d         = data_q;
        rsp_data_d     = rsp_data_q;
        rsp_is_write_d = rsp_is_write_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    owner_d    = grant_idx;
                    is_alloc_d = req_is_alloc_i[grant_idx];
                    data_d     = req_data_i[grant_idx*DATA_W +: DATA_W];
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (fal_req_ready_i) begin
                    state_d = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (fal_rsp_valid_i) begin
                    rsp_data_d     = fal_rsp_data_i;
                    rsp_is_write_d = fal_rsp_is_write_i;
                    state_d        = StDeliver;
                end
            end
            StDeliver: begin
                // Pointer moves on completion, not on accept.
                if (rsp_ready_i[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            owner_q        <= '0;
            last_grant_q   <= IDX_W'(NUM_REQ - 1);
            is_alloc_q     <= 1'b0;
            data_q         <= '0;
            rsp_data_q     <= '0;
            rsp_is_write_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            is_alloc_q     <= is_alloc_d;
            data_q         <= data_d;
            rsp_data_q     <= rsp_data_d;
            rsp_is_write_q <= rsp_is_write_d;
        end
    end

    // All falafel-side outputs decode straight from flops, so they stay stable while
    // ISSUE is held by backpressure.
    always_comb begin
        req_ready_o     = '0;
        rsp_valid_o     = '0;
        fal_req_valid_o = 1'b0;
        fal_is_alloc_o  = 1'b0;
        fal_size_o      = '0;
        fal_addr_o      = '0;
        fal_rsp_ready_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    req_ready_o = OneHotLsb << grant_idx;
                end
            end
            StIssue: begin
                fal_req_valid_o = 1'b1;
                fal_is_alloc_o  = is_alloc_q;
                if (is_alloc_q) begin
                    fal_size_o = data_q;
                end else begin
                    fal_addr_o = data_q;
                end
            end
            StWaitRsp: fal_rsp_ready_o = 1'b1;
            StDeliver: rsp_valid_o = OneHotLsb << owner_q;
            default: ;
        endcase
    end

    assign rsp_data_o     = rsp_data_q;
    assign rsp_is_write_o = rsp_is_write_q;
    assign owner_o        = owner_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_falafel_req_arbiter.sv
module tb_falafel_req_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned IDX_W   = 2;

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ-1:0]        req_is_alloc_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [NUM_REQ-1:0]        rsp_ready_i;
    logic [DATA_W-1:0]         rsp_data_o;
    logic                      rsp_is_write_o;
    logic                      fal_req_valid_o;
    logic                      fal_req_ready_i;
    logic                      fal_is_alloc_o;
    logic [DATA_W-1:0]         fal_size_o;
    logic [DATA_W-1:0]         fal_addr_o;
    logic                      fal_rsp_valid_i;
    logic                      fal_rsp_ready_o;
    logic [DATA_W-1:0]         fal_rsp_data_i;
    logic                      fal_rsp_is_write_i;
    logic [IDX_W-1:0]          owner_o;
    logic                      busy_o;

    falafel_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_is_alloc_i     (req_is_alloc_i),
        .req_data_i         (req_data_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_data_o         (rsp_data_o),
        .rsp_is_write_o     (rsp_is_write_o),
        .fal_req_valid_o    (fal_req_valid_o),
        .fal_req_ready_i    (fal_req_ready_i),
        .fal_is_alloc_o     (fal_is_alloc_o),
        .fal_size_o         (fal_size_o),
        .fal_addr_o         (fal_addr_o),
        .fal_rsp_valid_i    (fal_rsp_valid_i),
        .fal_rsp_ready_o    (fal_rsp_ready_o),
        .fal_rsp_data_i     (fal_rsp_data_i),
        .fal_rsp_is_write_i (fal_rsp_is_write_i),
        .owner_o            (owner_o),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned owner;
        logic [63:0] data;
        logic        is_write;
    } rsp_t;

    typedef struct {
        logic        is_alloc;
        logic [63:0] data;
    } iss_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    rsp_t        sb_q[$];
    iss_t        iss_q[$];
    int unsigned grant_log[$];
    int unsigned exp_last = NUM_REQ - 1;

    int unsigned pend_cnt[NUM_REQ];
    logic        pend_alloc[NUM_REQ];
    logic [63:0] pend_data[NUM_REQ];

    bit          mdl_en = 1'b1;
    int unsigned mdl_stall = 0;
    int unsigned mdl_lat = 1;

    // Reference falafel behaviour: allocation returns size<<6, free returns addr+1.
    function automatic logic [63:0] fal_result(input logic is_alloc, input logic [63:0] d);
        return is_alloc ? (d << 6) : (d + 64'd1);
    endfunction

    function automatic bit all_idle_pend();
        for (int i = 0; i < NUM_REQ; i++) if (pend_cnt[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Requester agent: presents pending ops, records grants, pushes expectations.
    initial begin
        logic [NUM_REQ-1:0] acc;
        req_valid_i    = '0;
        req_is_alloc_i = '0;
        req_data_i     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_cnt[i] = 0; pend_alloc[i] = 1'b1; pend_data[i] = '0;
        end
        forever begin
            @(negedge clk_i);
            acc = '0;
            if (rst_ni) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid_i[i] && req_ready_o[i]) begin
                        acc[i] = 1'b1;
                        sb_q.push_back('{owner: i,
                            data: fal_result(req_is_alloc_i[i], req_data_i[i*DATA_W +: DATA_W]),
                            is_write: req_is_alloc_i[i]});
                        iss_q.push_back('{is_alloc: req_is_alloc_i[i],
                                          data: req_data_i[i*DATA_W +: DATA_W]});
                        grant_log.push_back(i);
                    end
                end
            end
            @(posedge clk_i);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && pend_cnt[i] != 0) begin
                    pend_cnt[i]  = pend_cnt[i] - 1;
                    pend_data[i] = pend_data[i] + 64'h10;
                end
                req_valid_i[i]                   = (pend_cnt[i] != 0);
                req_is_alloc_i[i]                = pend_alloc[i];
                req_data_i[i*DATA_W +: DATA_W]   = pend_data[i];
            end
        end
    end

    // Falafel model: optional ready stall, fixed result latency, checks issued request.
    initial begin
        int unsigned phase;
        int unsigned cnt;
        logic        cur_alloc;
        logic [63:0] cur_data;
        iss_t        e;
        phase = 0; cnt = 0; cur_alloc = 1'b0; cur_data = '0;
        fal_req_ready_i = 1'b0; fal_rsp_valid_i = 1'b0;
        fal_rsp_data_i = '0; fal_rsp_is_write_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                phase = 0; cnt = 0;
                if (mdl_en) begin
                    fal_req_ready_i = 1'b0; fal_rsp_valid_i = 1'b0;
                end
            end else if (mdl_en) begin
                case (phase)
                    0: begin
                        fal_rsp_valid_i = 1'b0;
                        fal_req_ready_i = 1'b0;
                        if (fal_req_valid_o) begin
                            if (cnt < mdl_stall) begin
                                cnt++;
                            end else begin
                                fal_req_ready_i = 1'b1;
                                cnt = 0; phase = 1;
                                cur_alloc = fal_is_alloc_o;
                                cur_data  = fal_is_alloc_o ? fal_size_o : fal_addr_o;
                                n_checks++;
                                if (iss_q.size() == 0) begin
                                    n_fail++;
                                    $display("FAIL fal_issue: unexpected issue alloc=%0b size=%h addr=%h",
                                             fal_is_alloc_o, fal_size_o, fal_addr_o);
                                end else begin
                                    e = iss_q.pop_front();
                                    if ({fal_is_alloc_o, fal_size_o, fal_addr_o} !==
                                        {e.is_alloc, e.is_alloc ? e.data : 64'd0,
                                         e.is_alloc ? 64'd0 : e.data}) begin
                                        n_fail++;
                                        $display("FAIL fal_issue: got alloc=%0b size=%h addr=%h expected alloc=%0b data=%h",
                                                 fal_is_alloc_o, fal_size_o, fal_addr_o, e.is_alloc, e.data);
                                    end
                                end
                            end
                        end
                    end
                    1: begin
                        fal_req_ready_i = 1'b0;
                        cnt++;
                        if (cnt >= mdl_lat) begin
                            fal_rsp_valid_i    = 1'b1;
                            fal_rsp_data_i     = fal_result(cur_alloc, cur_data);
                            fal_rsp_is_write_i = cur_alloc;
                            cnt = 0;
                            phase = fal_rsp_ready_o ? 3 : 2;
                        end
                    end
                    2: if (fal_rsp_ready_o) phase = 3;
                    default: begin
                        fal_rsp_valid_i = 1'b0;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // Response monitor: one-hot sanity and scoreboard pop on each delivered result.
    always @(negedge clk_i) begin
        rsp_t got;
        int   idx;
        if (rst_ni) begin
            n_checks++;
            if (!$onehot0(req_ready_o) || !$onehot0(rsp_valid_o)) begin
                n_fail++;
                $display("FAIL onehot: req_ready_o=%b rsp_valid_o=%b required one-hot or zero",
                         req_ready_o, rsp_valid_o);
            end
            if ((rsp_valid_o & rsp_ready_i) != '0) begin
                idx = 0;
                for (int i = 0; i < NUM_REQ; i++) if (rsp_valid_o[i]) idx = i;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_route: unexpected result to %0d data=%h", idx, rsp_data_o);
                end else begin
                    got = sb_q.pop_front();
                    exp_last = got.owner;
                    if (idx !== int'(got.owner) || rsp_data_o !== got.data ||
                        rsp_is_write_o !== got.is_write || 32'(owner_o) !== got.owner) begin
                        n_fail++;
                        $display("FAIL rsp_route: got idx=%0d owner=%0d data=%h wr=%0b expected owner=%0d data=%h wr=%0b",
                                 idx, owner_o, rsp_data_o, rsp_is_write_o,
                                 got.owner, got.data, got.is_write);
                    end
                end
            end
        end
    end

    task automatic wait_done(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned c = 0; c < budget; c++) begin
            @(negedge clk_i);
            if (all_idle_pend() && req_valid_i == '0 && !busy_o && sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rsp_ready_i = '1;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({req_ready_o, rsp_valid_o, busy_o, fal_req_valid_o, fal_rsp_ready_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0",
                     {req_ready_o, rsp_valid_o, busy_o, fal_req_valid_o, fal_rsp_ready_o});
        end
        n_checks++;
        if ({owner_o, fal_is_alloc_o, fal_size_o, fal_addr_o, rsp_data_o, rsp_is_write_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: owner=%0d size=%h addr=%h rsp=%h required 0",
                     owner_o, fal_size_o, fal_addr_o, rsp_data_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single();
        bit seen;
        bit ok;
        mdl_stall = 0; mdl_lat = 5;
        pend_alloc[2] = 1'b1; pend_data[2] = 64'h40; pend_cnt[2] = 1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_i);
            seen = req_ready_o[2];
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL single_accept: req_ready_o[2] never asserted, got %b", req_ready_o);
        end
        @(negedge clk_i);
        n_checks++;
        if ({fal_req_valid_o, fal_is_alloc_o, fal_size_o, fal_addr_o} !== {1'b1, 1'b1, 64'h40, 64'h0}) begin
            n_fail++;
            $display("FAIL single_issue: valid=%0b alloc=%0b size=%h addr=%h required 1 1 40 0",
                     fal_req_valid_o, fal_is_alloc_o, fal_size_o, fal_addr_o);
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (rsp_valid_o != '0) seen = 1'b1;
            else @(negedge clk_i);
        end
        n_checks++;
        if (rsp_valid_o !== 4'b0100 || rsp_data_o !== 64'h1000 || rsp_is_write_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_rsp: rsp_valid_o=%b data=%h wr=%0b required 0100 1000 1",
                     rsp_valid_o, rsp_data_o, rsp_is_write_o);
        end
        wait_done(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_done: timeout got 0 required 1"); end
    endtask

    task automatic test_free();
        bit seen;
        bit ok;
        int lat;
        mdl_stall = 0; mdl_lat = 1;
        pend_alloc[1] = 1'b0; pend_data[1] = 64'h2000; pend_cnt[1] = 1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_i);
            seen = req_ready_o[1];
        end
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            if (c == 1) begin
                n_checks++;
                if ({fal_req_valid_o, fal_is_alloc_o, fal_size_o, fal_addr_o} !==
                    {1'b1, 1'b0, 64'h0, 64'h2000}) begin
                    n_fail++;
                    $display("FAIL free_issue: valid=%0b alloc=%0b size=%h addr=%h required 1 0 0 2000",
                             fal_req_valid_o, fal_is_alloc_o, fal_size_o, fal_addr_o);
                end
            end
            if (rsp_valid_o != '0) begin lat = c; break; end
        end
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL min_latency: accept-to-rsp got %0d cycles required 3", lat);
        end
        n_checks++;
        if (rsp_valid_o !== 4'b0010 || rsp_data_o !== 64'h2001 || rsp_is_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL free_rsp: rsp_valid_o=%b data=%h wr=%0b required 0010 2001 0",
                     rsp_valid_o, rsp_data_o, rsp_is_write_o);
        end
        wait_done(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL free_done: timeout got 0 required 1"); end
    endtask

    task automatic test_fairness();
        int unsigned start;
        int          run;
        int          max_run;
        bit          ok;
        mdl_stall = 0; mdl_lat = 1;
        grant_log.delete();
        start = (exp_last + 1) % NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_alloc[i] = 1'b1; pend_data[i] = 64'h100 * (i + 1); pend_cnt[i] = 2;
        end
        run = 0; max_run = 0;
        for (int c = 0; c < 300 && grant_log.size() < 8; c++) begin
            @(negedge clk_i);
            if (grant_log.size() > 0) begin
                if (!busy_o) run++;
                else run = 0;
                if (run > max_run) max_run = run;
            end
        end
        n_checks++;
        if (grant_log.size() != 8) begin
            n_fail++;
            $display("FAIL fair_count: got %0d grants required 8", grant_log.size());
        end
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
            n_checks++;
            if (grant_log[k] != (start + k) % NUM_REQ) begin
                n_fail++;
                $display("FAIL fair_order[%0d]: got %0d required %0d", k, grant_log[k],
                         (start + k) % NUM_REQ);
            end
        end
        n_checks++;
        if (max_run > 1) begin
            n_fail++;
            $display("FAIL fair_gap: busy_o low for %0d cycles required at most 1", max_run);
        end
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fair_done: timeout got 0 required 1"); end
    endtask

    task automatic test_backpressure();
        bit          seen;
        bit          ok;
        logic [129:0] snap;
        mdl_stall = 10; mdl_lat = 1;
        rsp_ready_i[3] = 1'b0;
        pend_alloc[3] = 1'b1; pend_data[3] = 64'h300; pend_cnt[3] = 1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_i);
            seen = fal_req_valid_o;
        end
        snap = {fal_req_valid_o, fal_is_alloc_o, fal_size_o, fal_addr_o};
        n_checks++;
        if (snap !== {1'b1, 1'b1, 64'h300, 64'h0}) begin
            n_fail++;
            $display("FAIL bp_issue: got %h required valid alloc size 300", snap);
        end
        pend_alloc[0] = 1'b0; pend_data[0] = 64'h700; pend_cnt[0] = 1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({fal_req_valid_o, fal_is_alloc_o, fal_size_o, fal_addr_o} !== snap ||
                req_ready_o !== '0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: fal=%h req_ready_o=%b required %h 0000", k,
                         {fal_req_valid_o, fal_is_alloc_o, fal_size_o, fal_addr_o},
                         req_ready_o, snap);
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_i);
            seen = (rsp_valid_o != '0);
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (rsp_valid_o !== 4'b1000 || rsp_data_o !== 64'hC000 || req_ready_o !== '0 ||
                busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_rsp_hold[%0d]: rsp_valid_o=%b data=%h req_ready_o=%b busy=%0b required 1000 c000 0000 1",
                         k, rsp_valid_o, rsp_data_o, req_ready_o, busy_o);
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        rsp_ready_i[3] = 1'b1;
        mdl_stall = 0;
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_done: timeout got 0 required 1"); end
    endtask

    task automatic test_spurious();
        bit seen;
        bit ok;
        @(negedge clk_i);
        mdl_en = 1'b0;
        fal_req_ready_i = 1'b0;
        fal_rsp_valid_i = 1'b1; fal_rsp_data_i = 64'hDEAD; fal_rsp_is_write_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            n_checks++;
            if (fal_rsp_ready_o !== 1'b0 || rsp_valid_o !== '0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL spur_idle: fal_rsp_ready_o=%0b rsp_valid_o=%b busy=%0b required 0",
                         fal_rsp_ready_o, rsp_valid_o, busy_o);
            end
        end
        fal_rsp_valid_i = 1'b0;
        pend_alloc[0] = 1'b1; pend_data[0] = 64'h10; pend_cnt[0] = 1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_i);
            seen = fal_req_valid_o;
        end
        fal_rsp_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            n_checks++;
            if (fal_rsp_ready_o !== 1'b0 || fal_req_valid_o !== 1'b1 || rsp_valid_o !== '0) begin
                n_fail++;
                $display("FAIL spur_issue: fal_rsp_ready_o=%0b fal_req_valid_o=%0b rsp_valid_o=%b required 0 1 0",
                         fal_rsp_ready_o, fal_req_valid_o, rsp_valid_o);
            end
        end
        fal_rsp_valid_i = 1'b0;
        fal_rsp_data_i = '0;
        @(posedge clk_i);
        #1;
        mdl_stall = 0; mdl_lat = 1; mdl_en = 1'b1;
        wait_done(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL spur_done: timeout got 0 required 1"); end
    endtask

    task automatic test_reset_midop();
        bit seen;
        bit ok;
        mdl_stall = 0; mdl_lat = 20;
        pend_alloc[2] = 1'b0; pend_data[2] = 64'h500; pend_cnt[2] = 1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_i);
            seen = fal_rsp_ready_o;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rst_reach_wait: got 0 required 1"); end
        for (int i = 0; i < NUM_REQ; i++) pend_cnt[i] = 0;
        req_valid_i = '0;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({req_ready_o, rsp_valid_o, busy_o, fal_req_valid_o, fal_rsp_ready_o, owner_o,
             fal_is_alloc_o, fal_size_o, fal_addr_o, rsp_data_o, rsp_is_write_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: busy=%0b fal_rsp_ready=%0b owner=%0d rsp_data=%h required all 0",
                     busy_o, fal_rsp_ready_o, owner_o, rsp_data_o);
        end
        sb_q.delete(); iss_q.delete(); grant_log.delete();
        exp_last = NUM_REQ - 1;
        mdl_lat = 1;
        repeat (2) @(negedge clk_i);
        pend_alloc[0] = 1'b1; pend_data[0] = 64'h20; pend_cnt[0] = 1;
        pend_alloc[3] = 1'b1; pend_data[3] = 64'h30; pend_cnt[3] = 1;
        rst_ni = 1'b1;
        wait_done(100, ok);
        n_checks++;
        if (!ok || grant_log.size() != 2) begin
            n_fail++;
            $display("FAIL rst_after: done=%0b grants=%0d required 1 2", ok, grant_log.size());
        end else begin
            n_checks++;
            if (grant_log[0] != 0 || grant_log[1] != 3) begin
                n_fail++;
                $display("FAIL rst_priority: order %0d,%0d required 0,3", grant_log[0], grant_log[1]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_ready_i = '1;
        test_reset();
        test_single();
        test_free();
        test_fairness();
        test_backpressure();
        test_spurious();
        test_reset_midop();
        repeat (2) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
